// File: rtl/ecm_out_sched.sv
// ECM packet read-out scheduler: pops descriptors, streams packet words from the
// data RAM through a 2-entry skid buffer and enforces a minimum packet spacing.
module ecm_out_sched #(
  parameter logic [15:0] MIN_GAP              = 16'd1504,
  parameter logic [8:0]  MAX_LEN              = 9'd384,
  parameter int          ECM_DATARAM_DEPTHBIT = 9
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ecm_enable,
  input  logic                            ecm_pkt_rdy,
  output logic                            ecm_fifo_rden,
  input  logic [17:0]                     ecm_fifo_dout,
  output logic [ECM_DATARAM_DEPTHBIT-1:0] ecm_dataram_raddr,
  input  logic [15:0]                     ecm_dataram_rdata,
  output logic                            ecm_out_val,
  input  logic                            ecm_out_rdy,
  output logic [15:0]                     ecm_out_data,
  output logic                            ecm_out_sof,
  output logic                            ecm_out_eof,
  output logic                            ecm_busy,
  output logic                            ecm_len_err,
  output logic [15:0]                     ecm_sent_cnt
);
  localparam int          AW       = ECM_DATARAM_DEPTHBIT;
  localparam logic [15:0] GAP_LOAD = (MIN_GAP == 16'd0) ? 16'd0 : MIN_GAP - 16'd1;

  typedef enum logic [2:0] {IDLE, POP, LOAD, SEND, GAP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   gap_q, gap_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [7:0]    reads_left_q, reads_left_d;
  logic [7:0]    nwords_q, nwords_d;
  logic [7:0]    idx_q, idx_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          inflight_q, inflight_d;
  logic [15:0]   buf0_q, buf0_d, buf1_q, buf1_d;
  logic          rden_q, rden_d;
  logic          busy_q, busy_d;
  logic          len_err_q, len_err_d;
  logic [15:0]   sent_q, sent_d;

  logic [8:0]    desc_len;
  logic [AW-1:0] desc_addr;
  logic          desc_bad;
  logic          out_val, xfer, last_word, issue;
  logic [1:0]    occupancy;

  assign desc_len  = ecm_fifo_dout[8:0];
  assign desc_addr = AW'(ecm_fifo_dout[17:9]);
  assign desc_bad  = (desc_len == 9'd0) || (desc_len > MAX_LEN) || desc_len[0];

  // A word is presentable from the skid head, or straight from the RAM when the buffer is empty.
  assign out_val   = (cnt_q != 2'd0) || inflight_q;
  assign xfer      = out_val && ecm_out_rdy;
  assign last_word = (idx_q == nwords_q - 8'd1);
  assign occupancy = cnt_q + {1'b0, inflight_q};
  assign issue     = (state_q == SEND) && (reads_left_q != 8'd0) && (occupancy < 2'd2);

  always_comb begin
    state_d      = state_q;
    gap_d        = (gap_q != 16'd0) ? gap_q - 16'd1 : 16'd0;
    raddr_d      = raddr_q;
    reads_left_d = reads_left_q;
    nwords_d     = nwords_q;
    idx_d        = idx_q;
    sent_d       = sent_q;
    len_err_d    = 1'b0;
    inflight_d   = issue;
    cnt_d        = cnt_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;

    if (issue) begin
      raddr_d      = raddr_q + AW'(1);
      reads_left_d = reads_left_q - 8'd1;
    end

    if (xfer) begin
      idx_d = idx_q + 8'd1;
      if (idx_q == 8'd0) gap_d = GAP_LOAD;
    end

    if (xfer && (cnt_q != 2'd0)) begin
      buf0_d = buf1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (inflight_q && !(xfer && (cnt_q == 2'd0))) begin
      if (cnt_d == 2'd0) buf0_d = ecm_dataram_rdata;
      else               buf1_d = ecm_dataram_rdata;
      cnt_d = cnt_d + 2'd1;
    end

    // Thresholds look ahead so the next pop lands exactly MIN_GAP cycles after sof.
    case (state_q)
      IDLE: if (ecm_enable && ecm_pkt_rdy && (gap_q <= 16'd1)) state_d = POP;
      POP:  state_d = LOAD;
      LOAD: begin
        if (desc_bad) begin
          len_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          raddr_d      = desc_addr;
          reads_left_d = desc_len[8:1];
          nwords_d     = desc_len[8:1];
          idx_d        = 8'd0;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (xfer && last_word) begin
          sent_d  = sent_q + 16'd1;
          state_d = (gap_q > 16'd2) ? GAP : IDLE;
        end
      end
      GAP:     if (gap_q <= 16'd2) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rden_d = (state_d == POP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gap_q        <= 16'd0;
      raddr_q      <= '0;
      reads_left_q <= 8'd0;
      nwords_q     <= 8'd0;
      idx_q        <= 8'd0;
      cnt_q        <= 2'd0;
      inflight_q   <= 1'b0;
      buf0_q       <= 16'd0;
      buf1_q       <= 16'd0;
      rden_q       <= 1'b0;
      busy_q       <= 1'b0;
      len_err_q    <= 1'b0;
      sent_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      raddr_q      <= raddr_d;
      reads_left_q <= reads_left_d;
      nwords_q     <= nwords_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      rden_q       <= rden_d;
      busy_q       <= busy_d;
      len_err_q    <= len_err_d;
      sent_q       <= sent_d;
    end
  end

  assign ecm_fifo_rden     = rden_q;
  assign ecm_dataram_raddr = raddr_q;
  assign ecm_out_val       = out_val;
  assign ecm_out_data      = (cnt_q != 2'd0) ? buf0_q : (inflight_q ? ecm_dataram_rdata : 16'd0);
  assign ecm_out_sof       = out_val && (idx_q == 8'd0);
  assign ecm_out_eof       = out_val && last_word;
  assign ecm_busy          = busy_q;
  assign ecm_len_err       = len_err_q;
  assign ecm_sent_cnt      = sent_q;
endmodule
